// File: rtl/data_sram_resp_if.sv
// Bundles the data_sram request/response wires between the CPU (master) and the data memory (slave).
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Byte-writable single-port data memory with window check, sticky error record and saturating counters.
// Read data returns 1 cycle after the request; no backpressure, a request is accepted every cycle.
module data_sram_resp #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    data_sram_resp_if.slave    bus,
    output logic               addr_err,
    output logic [31:0]        err_addr,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [CNT_W-1:0]   wr_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] idx;
    logic              in_win;
    logic              unused_lsb;

    assign idx        = bus.data_sram_addr[ADDR_W+1:2];
    assign in_win     = (bus.data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign unused_lsb = ^bus.data_sram_addr[1:0];

    assign bus.data_sram_rdata = rdata_q;

    // The array lives in the reset process only so that a request landing on a reset edge is dropped;
    // it is never cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            addr_err <= 1'b0;
            err_addr <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else if (bus.data_sram_en) begin
            if (in_win) begin
                rdata_q <= mem[idx];
                if (bus.data_sram_wen == 4'b0000) begin
                    if (rd_cnt != CNT_MAX)
                        rd_cnt <= rd_cnt + CNT_ONE;
                end else begin
                    if (wr_cnt != CNT_MAX)
                        wr_cnt <= wr_cnt + CNT_ONE;
                    for (int i = 0; i < 4; i++) begin
                        if (bus.data_sram_wen[i])
                            mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= '0;
                if (!addr_err) begin
                    addr_err <= 1'b1;
                    err_addr <= bus.data_sram_addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    data_sram_resp_if bus ();
    data_sram_resp_if bus2 ();

    logic        addr_err, addr_err2;
    logic [31:0] err_addr, err_addr2;
    logic [15:0] rd_cnt, wr_cnt;
    logic [1:0]  rd_cnt2, wr_cnt2;

    data_sram_resp #(.ADDR_W(12), .BASE_ADDR(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .addr_err(addr_err), .err_addr(err_addr), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    data_sram_resp #(.ADDR_W(12), .BASE_ADDR(32'h0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus2),
        .addr_err(addr_err2), .err_addr(err_addr2), .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [31:0] m_mem [4096];
    logic [31:0] m_last = 32'h0;
    logic        m_err = 1'b0;
    logic [31:0] m_eaddr = 32'h0;
    logic [15:0] m_rd = 16'h0;
    logic [15:0] m_wr = 16'h0;
    logic [31:0] sb_q [$];

    task automatic model_reset();
        m_last  = 32'h0;
        m_err   = 1'b0;
        m_eaddr = 32'h0;
        m_rd    = 16'h0;
        m_wr    = 16'h0;
    endtask

    task automatic req(input string tag, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] e;
        logic [11:0] ix;
        @(negedge clk);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        ix = addr[13:2];
        e  = m_last;
        if (en) begin
            if (addr[31:14] != 18'h0) begin
                e = 32'h0;
                if (!m_err) begin
                    m_err   = 1'b1;
                    m_eaddr = addr;
                end
            end else begin
                e = m_mem[ix];
                if (wen == 4'h0) begin
                    if (m_rd != 16'hFFFF) m_rd = m_rd + 16'h1;
                end else begin
                    if (m_wr != 16'hFFFF) m_wr = m_wr + 16'h1;
                    for (int i = 0; i < 4; i++)
                        if (wen[i]) m_mem[ix][8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
        m_last = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            if (!$isunknown(e)) chk({tag, "_rdata"}, bus.data_sram_rdata, e);
        end
        chk({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(m_rd));
        chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(m_wr));
        chk({tag, "_addr_err"}, 32'(addr_err), 32'(m_err));
        chk({tag, "_err_addr"}, err_addr, m_eaddr);
    endtask

    initial begin
        bus.data_sram_en     = 1'b0;
        bus.data_sram_wen    = 4'h0;
        bus.data_sram_addr   = 32'h0;
        bus.data_sram_wdata  = 32'h0;
        bus2.data_sram_en    = 1'b0;
        bus2.data_sram_wen   = 4'h0;
        bus2.data_sram_addr  = 32'h0;
        bus2.data_sram_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", bus.data_sram_rdata, 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'h0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        req("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        req("rd10", 1'b1, 4'h0, 32'h10, 32'h0);
        chk("rd10_value", bus.data_sram_rdata, 32'hDEADBEEF);

        req("wr20", 1'b1, 4'hF, 32'h20, 32'h11223344);
        req("wr20p", 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        req("rd20", 1'b1, 4'h0, 32'h20, 32'h0);
        chk("rd20_merge", bus.data_sram_rdata, 32'h11BB33DD);

        req("wr30a", 1'b1, 4'hF, 32'h30, 32'h1);
        req("wr30b", 1'b1, 4'hF, 32'h30, 32'h2);
        req("rd30", 1'b1, 4'h0, 32'h30, 32'h0);

        req("rd10b", 1'b1, 4'h0, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) req("idle", 1'b0, 4'h0, 32'h10, 32'h0);
        req("rd13", 1'b1, 4'h0, 32'h13, 32'h0);

        req("wr00", 1'b1, 4'hF, 32'h0, 32'hCAFEF00D);
        req("oow_wr", 1'b1, 4'hF, 32'h0000_4000, 32'h12345678);
        req("rd00", 1'b1, 4'h0, 32'h0, 32'h0);
        req("oow_rd", 1'b1, 4'h0, 32'h8000_0000, 32'h0);
        chk("err_addr_first", err_addr, 32'h0000_4000);

        // Asynchronous reset mid-cycle, with a write request held across a reset edge
        #2;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'hF;
        bus.data_sram_addr  = 32'h10;
        bus.data_sram_wdata = 32'h0;
        rst = 1'b1;
        #1;
        chk("arst_rdata", bus.data_sram_rdata, 32'h0);
        chk("arst_addr_err", 32'(addr_err), 32'h0);
        chk("arst_err_addr", err_addr, 32'h0);
        chk("arst_rd_cnt", 32'(rd_cnt), 32'h0);
        chk("arst_wr_cnt", 32'(wr_cnt), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        bus.data_sram_en = 1'b0;
        rst = 1'b0;
        req("post_rst_rd10", 1'b1, 4'h0, 32'h10, 32'h0);
        chk("post_rst_keep10", bus.data_sram_rdata, 32'hDEADBEEF);
        req("post_rst_rd20", 1'b1, 4'h0, 32'h20, 32'h0);
        req("idle_end", 1'b0, 4'h0, 32'h0, 32'h0);

        // Counter saturation on the narrow-counter instance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.data_sram_en   = 1'b1;
            bus2.data_sram_wen  = 4'h0;
            bus2.data_sram_addr = 32'h4;
            @(posedge clk);
            #1;
            chk("sat_rd_cnt", 32'(rd_cnt2), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            chk("sat_wr_cnt", 32'(wr_cnt2), 32'h0);
        end
        @(negedge clk);
        bus2.data_sram_en = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
Single-port, byte-writable synchronous data memory that answers the CPU's data_sram request interface. The EX stage issues the request and the MEM stage consumes data_sram_rdata on the following cycle; this block is the memory side of that interface. It returns read data with fixed one-cycle latency and checks every address against its window. It also keeps saturating access counters and a sticky out-of-window error record for debug and bench checking.

Parameters:
ADDR_W, 12, word-address width; depth = 2**ADDR_W 32-bit words
BASE_ADDR, 32'h0000_0000, window base; only bits [31:ADDR_W+2] are significant
CNT_W, 16, width of the read and write access counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
data_sram_en  in  1  request valid this cycle
data_sram_wen  in  4  byte write enables; bit i -> byte lane i (bits 8i+7:8i); 0 = read
data_sram_addr  in  32  byte address; bits [1:0] ignored
data_sram_wdata  in  32  write data, lane-aligned
data_sram_rdata  out  32  registered read data
addr_err  out  1  sticky: an out-of-window access has occurred
err_addr  out  32  address of the first out-of-window access
rd_cnt  out  CNT_W  number of accepted in-window reads, saturating
wr_cnt  out  CNT_W  number of accepted in-window writes, saturating

Behaviour:
- Reset (rst=1, asynchronous): data_sram_rdata=0, addr_err=0, err_addr=0, rd_cnt=0, wr_cnt=0.
  - Memory array contents are not reset and are not changed by reset.
  - On release, the first edge with rst=0 processes the request present at that edge.
  - A request whose edge coincides with rst=1 is dropped entirely: no array write, no counter change.
- Word index = data_sram_addr[ADDR_W+1:2].
- In-window: data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
- Each rising edge, requests are classified as follows:
  - en=0: no array access; data_sram_rdata holds its previous value; counters hold.
  - en=1, wen=0, in-window (read): data_sram_rdata <= mem[idx] (1-cycle latency); rd_cnt += 1.
  - en=1, wen!=0, in-window (write):
    - For each i with wen[i]=1, mem[idx] lane i <= wdata lane i; other lanes are unchanged.
    - Read-first: data_sram_rdata <= the pre-write mem[idx].
    - wr_cnt += 1 once per request, regardless of how many lanes are enabled.
  - en=1, out-of-window (read or write):
    - No array write; data_sram_rdata <= 32'h0; counters hold.
    - If addr_err=0: addr_err <= 1 and err_addr <= data_sram_addr.
    - If addr_err is already 1: err_addr keeps the first faulting address. Only reset clears addr_err.
- Back-to-back requests are accepted every cycle with no stall and no bubble.
- A read of address A in the cycle after a write to A returns the post-write word (ordinary RAM ordering).
- Counters saturate at all-ones: an increment at max leaves the value at max and does not wrap.
- Lanes are fixed by address (little-endian). Sign/zero extension and sub-word alignment are the requester's job. Misaligned byte addresses are not an error; bits [1:0] are simply dropped.
- All outputs are registers; there is no combinational path from any input to any output.

Test Plan:
- Reset, then write addr 0x10 wen=4'hF wdata=32'hDEADBEEF, then read 0x10 -> rdata=32'hDEADBEEF one edge after the read; wr_cnt=1, rd_cnt=1.
- Write 0x20 with 32'h11223344 (wen=F), then wen=4'b0101 wdata=32'hAABBCCDD, then read 0x20 -> 32'h11BB33DD.
- Write 0x30=32'h0000_0001; then same-edge write 0x30 wen=F wdata=32'h0000_0002 -> rdata=32'h1 (read-first); next-cycle read -> 32'h2.
- Read 0x10 (rdata=DEADBEEF), then hold en=0 for 3 cycles -> rdata stays DEADBEEF, counters unchanged; read 0x13 -> DEADBEEF (low bits ignored).
- With BASE_ADDR=0 and ADDR_W=12:
  - Write 0x0000_4000 -> rdata=0, addr_err=1, err_addr=0x0000_4000, array unchanged.
  - Then read 0x8000_0000 -> err_addr stays 0x0000_4000.
  - Assert rst asynchronously mid-cycle -> all outputs 0 immediately, while earlier-written array data still reads back.
- CNT_W=2: issue 5 in-window reads -> rd_cnt sequence 1,2,3,3,3; wr_cnt=0.
